// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter
//   Arbitrates two write requesters (A and B) onto a single registered
//   register-file write port. After reset, a CLEAR sequence writes zero into
//   registers 0..NUM_REGS-1 one per cycle. The block then enters RUN, where
//   requests are granted round-robin. Each accepted request becomes a write
//   one cycle later.
//
//   Optional feature: define RF_ARB_R0_ZERO_EN to make r0 read-only during
//   RUN. Writes to address 0 are still accepted, but they are dropped. CLEAR
//   always zeroes r0.
//
// Ports
//   clk                      rising-edge clock
//   rst                      synchronous active-high reset
//   a_valid/a_addr/a_data    requester A write request
//   a_ready                  A accepted this cycle (when a_valid is high)
//   b_valid/b_addr/b_data    requester B write request
//   b_ready                  B accepted this cycle (when b_valid is high)
//   WE/WA/WD                 registered register-file write port
//   init_done                high once the clear sequence has completed
//   err_addr                 one-cycle pulse after an out-of-range address
//                            is accepted
module rf_write_arbiter #(
  parameter int NUM_REGS = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        a_valid,
  input  logic [4:0]  a_addr,
  input  logic [31:0] a_data,
  output logic        a_ready,
  input  logic        b_valid,
  input  logic [4:0]  b_addr,
  input  logic [31:0] b_data,
  output logic        b_ready,
  output logic        WE,
  output logic [4:0]  WA,
  output logic [31:0] WD,
  output logic        init_done,
  output logic        err_addr
);

  typedef enum logic {CLEAR, RUN} state_t;

  // The count is six bits wide so that NUM_REGS = 32 is representable.
  localparam logic [5:0] NREG = 6'(NUM_REGS);

  function automatic logic addr_in_range(input logic [4:0] addr);
    return {1'b0, addr} < NREG;
  endfunction

  function automatic logic addr_writable(input logic [4:0] addr);
`ifdef RF_ARB_R0_ZERO_EN
    return addr_in_range(addr) && (addr != 5'd0);
`else
    return addr_in_range(addr);
`endif
  endfunction

  state_t      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic        prio_q, prio_d;      // 0: A holds priority, 1: B holds priority
  logic        we_q, we_d;
  logic [4:0]  wa_q, wa_d;
  logic [31:0] wd_q, wd_d;
  logic        err_q, err_d;
  logic        init_q, init_d;

  logic        a_fire, b_fire;
  logic [4:0]  sel_addr;
  logic [31:0] sel_data;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    prio_d   = prio_q;
    we_d     = 1'b0;
    wa_d     = wa_q;
    wd_d     = wd_q;
    err_d    = 1'b0;
    init_d   = init_q;
    a_ready  = 1'b0;
    b_ready  = 1'b0;
    a_fire   = 1'b0;
    b_fire   = 1'b0;
    sel_addr = a_addr;
    sel_data = a_data;

    case (state_q)
      CLEAR: begin
        we_d = 1'b1;
        wa_d = cnt_q[4:0];
        wd_d = 32'd0;
        if (cnt_q == NREG - 6'd1) begin
          state_d = RUN;
          cnt_d   = 6'd0;
          init_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 6'd1;
        end
      end

      RUN: begin
        // A lone requester always wins. When both request, the
        // priority holder wins.
        a_ready = a_valid && (!b_valid || !prio_q);
        b_ready = b_valid && (!a_valid ||  prio_q);
        // Readies are suppressed during reset so that no transfer is
        // seen on a reset edge.
        if (rst) begin
          a_ready = 1'b0;
          b_ready = 1'b0;
        end
        a_fire = a_valid && a_ready;
        b_fire = b_valid && b_ready;
        if (b_fire) begin
          sel_addr = b_addr;
          sel_data = b_data;
        end
        if (a_fire || b_fire) begin
          prio_d = a_fire;          // hand priority to the other side
          err_d  = !addr_in_range(sel_addr);
          if (addr_writable(sel_addr)) begin
            we_d = 1'b1;
            wa_d = sel_addr;
            wd_d = sel_data;
          end
        end
      end

      default: state_d = CLEAR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= CLEAR;
      cnt_q   <= 6'd0;
      prio_q  <= 1'b0;
      we_q    <= 1'b0;
      wa_q    <= 5'd0;
      wd_q    <= 32'd0;
      err_q   <= 1'b0;
      init_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      prio_q  <= prio_d;
      we_q    <= we_d;
      wa_q    <= wa_d;
      wd_q    <= wd_d;
      err_q   <= err_d;
      init_q  <= init_d;
    end
  end

  assign WE        = we_q;
  assign WA        = wa_q;
  assign WD        = wd_q;
  assign err_addr  = err_q;
  assign init_done = init_q;

endmodule
